// File: rtl/axi4_sram_bridge.sv
// axi4_sram_bridge: AXI4 slave that maps 64-bit INCR bursts onto a two-port
// (W0 write / R0 read) synchronous SRAM macro with byte-masked writes and a
// one-cycle registered-address read latency. The macro shares this block's clock.
module axi4_sram_bridge #(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned MEM_AW = 25
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [ID_W-1:0]   aw_id,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic [7:0]        aw_len,
  input  logic [2:0]        aw_size,
  input  logic [1:0]        aw_burst,

  input  logic              w_valid,
  output logic              w_ready,
  input  logic [63:0]       w_data,
  input  logic [7:0]        w_strb,
  input  logic              w_last,

  output logic              b_valid,
  input  logic              b_ready,
  output logic [ID_W-1:0]   b_id,
  output logic [1:0]        b_resp,

  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ID_W-1:0]   ar_id,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [7:0]        ar_len,
  input  logic [2:0]        ar_size,
  input  logic [1:0]        ar_burst,

  output logic              r_valid,
  input  logic              r_ready,
  output logic [ID_W-1:0]   r_id,
  output logic [63:0]       r_data,
  output logic [1:0]        r_resp,
  output logic              r_last,

  output logic [MEM_AW-1:0] W0_addr,
  output logic              W0_en,
  output logic [63:0]       W0_data,
  output logic [7:0]        W0_mask,

  output logic [MEM_AW-1:0] R0_addr,
  output logic              R0_en,
  input  logic [63:0]       R0_data
);

  localparam int unsigned LEN_W = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'd3;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_CAPT  = 2'd2,
    R_DATA  = 2'd3
  } r_state_e;

  // ---------------------------------------------------------------------------
  // Write channel state
  // ---------------------------------------------------------------------------
  w_state_e          w_state;
  logic [ID_W-1:0]   w_id_q;
  logic [MEM_AW-1:0] w_idx_q;
  logic [LEN_W-1:0]  w_len_q;
  logic [LEN_W-1:0]  w_beat_q;
  logic              w_legal_q;
  logic              w_err_q;

  logic              w_hs_c;
  logic              w_final_c;
  logic              aw_legal_c;

  // ---------------------------------------------------------------------------
  // Read channel state
  // ---------------------------------------------------------------------------
  r_state_e          r_state;
  logic [MEM_AW-1:0] r_idx_q;
  logic [LEN_W-1:0]  r_len_q;
  logic [LEN_W-1:0]  r_beat_q;
  logic              r_legal_q;

  logic              r_final_c;
  logic              ar_legal_c;

  // Address bits outside the word index are intentionally ignored.
  logic              unused_ok;
  assign unused_ok = &{1'b0, aw_addr, ar_addr};

  // Burst legality and beat bookkeeping.
  assign aw_legal_c = (aw_burst == BURST_INCR) && (aw_size == SIZE_8B);
  assign ar_legal_c = (ar_burst == BURST_INCR) && (ar_size == SIZE_8B);
  assign w_hs_c     = w_valid && w_ready;
  assign w_final_c  = (w_beat_q == w_len_q);
  assign r_final_c  = (r_beat_q == r_len_q);

  // SRAM write port: each accepted W beat is written in its own cycle;
  // illegal bursts consume beats without touching the array.
  assign W0_en   = w_hs_c && w_legal_q;
  assign W0_addr = w_idx_q;
  assign W0_data = w_data;
  assign W0_mask = w_strb;

  // SRAM read port: a pending read yields to a write beat in the same cycle,
  // which also makes a later read of the same word observe the new data.
  assign R0_en   = (r_state == R_ISSUE) && r_legal_q && !W0_en;
  assign R0_addr = r_idx_q;

  // Write FSM: accept AW, stream W beats into W0, then hold the B response.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state   <= W_IDLE;
      aw_ready  <= 1'b0;
      w_ready   <= 1'b0;
      b_valid   <= 1'b0;
      b_id      <= '0;
      b_resp    <= RESP_OKAY;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_legal_q <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          aw_ready <= 1'b1;
          if (aw_valid && aw_ready) begin
            aw_ready  <= 1'b0;
            w_ready   <= 1'b1;
            w_id_q    <= aw_id;
            w_idx_q   <= aw_addr[MEM_AW+2:3];
            w_len_q   <= aw_len;
            w_beat_q  <= '0;
            w_legal_q <= aw_legal_c;
            w_err_q   <= 1'b0;
            w_state   <= W_DATA;
          end
        end

        W_DATA: begin
          if (w_hs_c) begin
            w_idx_q  <= w_idx_q + MEM_AW'(1);
            w_beat_q <= w_beat_q + LEN_W'(1);
            if (w_final_c) begin
              // Beat count alone ends the burst; a missing w_last is an error.
              w_ready <= 1'b0;
              b_valid <= 1'b1;
              b_id    <= w_id_q;
              b_resp  <= (!w_legal_q || w_err_q || !w_last) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else if (w_last) begin
              // Early w_last is flagged but does not shorten the burst.
              w_err_q <= 1'b1;
            end
          end
        end

        W_RESP: begin
          if (b_ready) begin
            b_valid  <= 1'b0;
            aw_ready <= 1'b1;
            w_state  <= W_IDLE;
          end
        end

        default: begin
          aw_ready <= 1'b0;
          w_ready  <= 1'b0;
          b_valid  <= 1'b0;
          w_state  <= W_IDLE;
        end
      endcase
    end
  end

  // Read FSM: issue one SRAM read per beat, capture it, then present it on R.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= R_IDLE;
      ar_ready  <= 1'b0;
      r_valid   <= 1'b0;
      r_id      <= '0;
      r_data    <= '0;
      r_resp    <= RESP_OKAY;
      r_last    <= 1'b0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_legal_q <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          ar_ready <= 1'b1;
          if (ar_valid && ar_ready) begin
            ar_ready  <= 1'b0;
            r_id      <= ar_id;
            r_idx_q   <= ar_addr[MEM_AW+2:3];
            r_len_q   <= ar_len;
            r_beat_q  <= '0;
            r_legal_q <= ar_legal_c;
            r_state   <= R_ISSUE;
          end
        end

        R_ISSUE: begin
          // Stalled for as long as the write port is busy this cycle.
          if (!W0_en) begin
            r_state <= R_CAPT;
          end
        end

        R_CAPT: begin
          // r_data doubles as the capture register for the SRAM read data.
          r_valid <= 1'b1;
          r_data  <= r_legal_q ? R0_data : '0;
          r_resp  <= r_legal_q ? RESP_OKAY : RESP_SLVERR;
          r_last  <= r_final_c;
          r_state <= R_DATA;
        end

        R_DATA: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            if (r_final_c) begin
              ar_ready <= 1'b1;
              r_state  <= R_IDLE;
            end else begin
              r_idx_q  <= r_idx_q + MEM_AW'(1);
              r_beat_q <= r_beat_q + LEN_W'(1);
              r_state  <= R_ISSUE;
            end
          end
        end

        default: begin
          ar_ready <= 1'b0;
          r_valid  <= 1'b0;
          r_state  <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axi4_sram_bridge.md
Name: axi4_sram_bridge

Overview:
- AXI4 slave front end that turns 64-bit AXI4 bursts into the two-port (W0/R0) synchronous SRAM macro interface used by the main memory and MMIO backing stores.
- Sits directly upstream of the SRAM macro.
- The SRAM has one-cycle registered-address read latency and byte-masked writes.
- The macro's R0/W0 clocks are tied to this block's clock.

Parameters:
- ID_W, 4, AXI ID width.
- ADDR_W, 32, AXI byte-address width.
- MEM_AW, 25, SRAM word-address width (25 for main memory, 9 for MMIO).

Ports:
- clock  in  1  single clock; also drives the SRAM W0_clk/R0_clk.
- reset  in  1  synchronous, active-high.
- aw_valid/aw_ready  in/out  1  AW handshake.
- aw_id  in  ID_W;  aw_addr  in  ADDR_W;  aw_len  in  8;  aw_size  in  3;  aw_burst  in  2.
- w_valid/w_ready  in/out  1;  w_data  in  64;  w_strb  in  8;  w_last  in  1.
- b_valid  out  1;  b_ready  in  1;  b_id  out  ID_W;  b_resp  out  2.
- ar_valid/ar_ready  in/out  1;  ar_id  in  ID_W;  ar_addr  in  ADDR_W;  ar_len  in  8;  ar_size  in  3;  ar_burst  in  2.
- r_valid  out  1;  r_ready  in  1;  r_id  out  ID_W;  r_data  out  64;  r_resp  out  2;  r_last  out  1.
- W0_addr  out  MEM_AW;  W0_en  out  1;  W0_data  out  64;  W0_mask  out  8.
- R0_addr  out  MEM_AW;  R0_en  out  1;  R0_data  in  64.

Behaviour:
- Reset (synchronous)
  - Both FSMs go to IDLE.
  - All valids and SRAM enables are 0; b_resp and r_resp are 0; r_data is 0.
  - aw_ready and ar_ready are 0 while reset is high and 1 in the first cycle after release.
  - Reset mid-burst abandons the burst: no B or R response is produced, and remaining beats are not written.
- Legality
  - A burst is legal only if burst = INCR (2'b01) and size = 3.
  - Illegal bursts are still accepted and run for the full beat count.
  - Illegal write burst: W beats are consumed, W0_en stays 0, and b_resp = SLVERR (2'b10).
  - Illegal read burst: r_data = 0 and r_resp = SLVERR on every beat; no R0_en.
- Addressing
  - Word index = addr[MEM_AW+2:3].
  - The word index increments by 1 per beat and wraps modulo 2^MEM_AW.
  - Low address bits [2:0] are ignored.
- Write FSM: W_IDLE -> W_DATA -> W_RESP.
  - W_IDLE: aw_ready=1. On the AW handshake, latch id, word index, beat count (len+1) and the legal flag.
  - W_DATA: w_ready=1. Each W handshake drives W0_en=legal in the same cycle, with W0_addr = current index, W0_data = w_data, W0_mask = w_strb.
  - In W_DATA, after the handshake of beat len+1 the FSM moves to W_RESP.
  - The beat count alone terminates the burst. A w_last value that mismatches (early or missing) sets b_resp = SLVERR but does not alter the beat count.
  - W_RESP: b_valid=1 and b_id = latched id; hold both until b_ready, then return to W_IDLE.
  - Minimum AW-to-b_valid latency for a one-beat burst: 2 cycles.
- Read FSM: R_IDLE -> R_ISSUE -> R_CAPT -> R_DATA.
  - R_IDLE: ar_ready=1. On the AR handshake, latch id, index, count and the legal flag.
  - R_ISSUE: drive R0_en=1 with R0_addr = index, unless W0_en is 1 in this cycle. Writes have priority, and the FSM stays in R_ISSUE while stalled.
  - R_CAPT: capture R0_data into rdata_q.
  - R_DATA: r_valid=1, r_data=rdata_q, r_last when on the final beat, r_resp=OKAY for legal bursts. Outputs are held stable until r_ready.
  - In R_DATA, on r_ready: if not the final beat, increment the index and go to R_ISSUE; if the final beat, go to R_IDLE.
  - Unstalled timing: AR handshake at cycle t gives R0_en at t+1 and r_valid at t+3; throughput is 1 beat per 3 cycles.
- Channel concurrency
  - The read and write channels run concurrently.
  - A read issued after a write beat to the same word returns the new data.
  - Because of the write priority rule, a read is never issued in the same cycle as a write beat.
- Mask handling: W0_mask = w_strb verbatim, so a zero strobe leads to W0_en=1 with mask 0 (no bytes change).

Test Plan:
- Single write, then read:
  - Stimulus: AW addr 0x8, len 0, w_data 0x0123_4567_89AB_CDEF, strb 0xFF; then AR addr 0x8, len 0.
  - Required response: W0_addr=1 with W0_en for 1 cycle; b_resp=0; r_data=0x0123_4567_89AB_CDEF with r_last=1 at t+3 from the AR handshake.
- Burst with partial strobe:
  - Stimulus: AW addr 0x0, len 3, strb 0x0F on beat 2.
  - Required response: W0_addr 0,1,2,3; mask 0xFF,0xFF,0x0F,0xFF; then a 4-beat read returns the merged bytes with r_last only on beat 4.
- Backpressure:
  - Stimulus: 2-beat read with r_ready held low for 5 cycles on beat 1.
  - Required response: r_data, r_valid and r_last=0 stable for all 5 cycles; no second R0_en until the handshake.
- Illegal bursts:
  - Stimulus: aw_burst=WRAP with len 1; separately ar_size=2.
  - Required response: write: 2 W beats accepted, W0_en never asserted, b_resp=2'b10. Read: r_data=0 and r_resp=2'b10 on every beat, R0_en never asserted.
- wlast mismatch and wrap:
  - Stimulus: MEM_AW=9, AW addr 0xFF8 (index 511), len 1, w_last on beat 1.
  - Required response: writes to index 511 then 0; b_resp=SLVERR.
- Collision and reset:
  - Stimulus: read issue coinciding with a write beat to the same word; separately, reset asserted during W_DATA.
  - Required response: collision: R0_en delayed 1 cycle and new data returned. Reset: no b_valid is produced, and aw_ready=1 the cycle after reset release.
